// File: rtl/debug_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : debug_program_loader
// Description : Debug-unit program writer for the IF-stage instruction memory.
//               Packs UART bytes MSB-first into NB_DATA-bit words and writes
//               them at consecutive word addresses from 0 until the HALT word
//               has been written or the memory is full.
// Revision    : 1.0 - initial release
// ============================================================================
module debug_program_loader #(
    parameter int                  NB_DATA    = 32,
    parameter int                  NB_BYTE    = 8,
    parameter int                  N_ELEMENTS = 128,
    parameter int                  ADDR_WIDTH = $clog2(N_ELEMENTS),
    parameter logic [NB_DATA-1:0]  HALT_WORD  = {NB_DATA{1'b1}}
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [NB_BYTE-1:0]    rx_data_i,
    input  logic                  rx_done_i,
    output logic [ADDR_WIDTH-1:0] wr_addr_o,
    output logic [NB_DATA-1:0]    instruction_o,
    output logic                  en_write_o,
    output logic                  busy_o,
    output logic                  load_done_o,
    output logic                  overflow_o,
    output logic [ADDR_WIDTH:0]   word_count_o
);

    localparam int N_BYTES = NB_DATA / NB_BYTE;
    localparam int CNT_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(N_BYTES - 1);
    localparam logic [CNT_W-1:0]      ONE_BYTE  = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_ELEMENTS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RECEIVE = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [CNT_W-1:0]      byte_cnt;
    logic [NB_DATA-1:0]    shreg;
    logic [NB_DATA-1:0]    shifted;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [NB_DATA-1:0]    instr_q;
    logic [ADDR_WIDTH:0]   word_count_q;
    logic                  load_done_q;
    logic                  overflow_q;
    logic                  is_halt;
    logic                  at_last_addr;

    // Incoming byte enters at the bottom, so the first byte ends up in the MSBs.
    assign shifted      = {shreg[NB_DATA-NB_BYTE-1:0], rx_data_i};
    assign is_halt      = (instr_q == HALT_WORD);
    assign at_last_addr = (addr == LAST_ADDR);

    // State register.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start_i only matters when no load is in progress.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_i) state_next = ST_RECEIVE;
            end
            ST_RECEIVE: begin
                if (rx_done_i && (byte_cnt == LAST_BYTE)) state_next = ST_WRITE;
            end
            ST_WRITE: begin
                if (is_halt || at_last_addr) state_next = ST_DONE;
                else                         state_next = ST_RECEIVE;
            end
            ST_DONE: begin
                if (start_i) state_next = ST_RECEIVE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: one write pulse per WRITE visit.
    always_comb begin
        en_write_o = (state == ST_WRITE);
        busy_o     = (state == ST_RECEIVE) || (state == ST_WRITE);
    end

    // Datapath: byte assembly, write-port registers, address and status flags.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            byte_cnt     <= '0;
            shreg        <= '0;
            addr         <= '0;
            wr_addr_q    <= '0;
            instr_q      <= '0;
            word_count_q <= '0;
            load_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        addr         <= '0;
                        byte_cnt     <= '0;
                        word_count_q <= '0;
                        load_done_q  <= 1'b0;
                        overflow_q   <= 1'b0;
                    end
                end
                ST_RECEIVE: begin
                    if (rx_done_i) begin
                        shreg <= shifted;
                        if (byte_cnt == LAST_BYTE) begin
                            // Latch the write port so it holds outside WRITE
                            // while the next word is already shifting in.
                            byte_cnt  <= '0;
                            instr_q   <= shifted;
                            wr_addr_q <= addr;
                        end else begin
                            byte_cnt <= byte_cnt + ONE_BYTE;
                        end
                    end
                end
                ST_WRITE: begin
                    word_count_q <= word_count_q + 1'b1;
                    if (is_halt) begin
                        load_done_q <= 1'b1;
                    end else if (at_last_addr) begin
                        // Memory full: address must not wrap.
                        load_done_q <= 1'b1;
                        overflow_q  <= 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                        // A byte arriving during WRITE starts the next word.
                        if (rx_done_i) begin
                            shreg    <= shifted;
                            byte_cnt <= ONE_BYTE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign wr_addr_o     = wr_addr_q;
    assign instruction_o = instr_q;
    assign word_count_o  = word_count_q;
    assign load_done_o   = load_done_q;
    assign overflow_o    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_program_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_debug_program_loader
// Description : Directed self-checking bench for debug_program_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debug_program_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic [6:0]  wr_addr;
    logic [31:0] instr;
    logic        en_write;
    logic        busy;
    logic        load_done;
    logic        overflow;
    logic [7:0]  word_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [6:0]  wq_addr[$];
    logic [31:0] wq_data[$];

    debug_program_loader dut (
        .clock_i      (clk),
        .reset_i      (rst),
        .start_i      (start),
        .rx_data_i    (rx_data),
        .rx_done_i    (rx_done),
        .wr_addr_o    (wr_addr),
        .instruction_o(instr),
        .en_write_o   (en_write),
        .busy_o       (busy),
        .load_done_o  (load_done),
        .overflow_o   (overflow),
        .word_count_o (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every memory write, sampled mid-cycle.
    always @(negedge clk) begin
        if (en_write === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(instr);
        end
    end

    // All stimulus tasks are entered and left 1ns after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wq_addr.delete();
        wq_data.delete();
        n_cmp++;
        if ({wr_addr, instr, en_write, busy, load_done, overflow, word_count} !== 51'd0) begin
            n_err++;
            $display("FAIL reset_outputs: addr=%h instr=%h en=%b busy=%b done=%b ovf=%b wc=%0d want all 0",
                     wr_addr, instr, en_write, busy, load_done, overflow, word_count);
        end
    endtask

    task automatic test_program();
        pulse_start();
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL prog_busy: got %b want 1", busy); end
        send_word(32'h20010005);
        // one cycle after the 4th strobe
        n_cmp++;
        if ({en_write, wr_addr, instr} !== {1'b1, 7'd0, 32'h20010005}) begin
            n_err++;
            $display("FAIL prog_w0: en=%b addr=%0d instr=%h want en=1 addr=0 instr=20010005", en_write, wr_addr, instr);
        end
        // first HALT byte coincides with WRITE
        send_word(32'hFFFFFFFF);
        n_cmp++;
        if ({en_write, wr_addr, instr} !== {1'b1, 7'd1, 32'hFFFFFFFF}) begin
            n_err++;
            $display("FAIL prog_w1: en=%b addr=%0d instr=%h want en=1 addr=1 instr=ffffffff", en_write, wr_addr, instr);
        end
        idle_cycle();
        n_cmp++;
        if ({en_write, busy, load_done, overflow, word_count} !== {1'b0, 1'b0, 1'b1, 1'b0, 8'd2}) begin
            n_err++;
            $display("FAIL prog_end: en=%b busy=%b done=%b ovf=%b wc=%0d want 0 0 1 0 2",
                     en_write, busy, load_done, overflow, word_count);
        end
        n_cmp++;
        if (wq_addr.size() !== 2) begin
            n_err++;
            $display("FAIL prog_nwrites: got %0d want 2", wq_addr.size());
        end
        n_cmp++;
        if (instr !== 32'hFFFFFFFF || wr_addr !== 7'd1) begin
            n_err++;
            $display("FAIL prog_hold: addr=%0d instr=%h want 1 ffffffff", wr_addr, instr);
        end
    endtask

    task automatic test_ignore_in_done();
        send_word(32'h12345678);
        idle_cycle();
        n_cmp++;
        if (wq_addr.size() !== 2 || word_count !== 8'd2 || load_done !== 1'b1) begin
            n_err++;
            $display("FAIL done_ignore: writes=%0d wc=%0d done=%b want 2 2 1", wq_addr.size(), word_count, load_done);
        end
    endtask

    task automatic test_no_start();
        test_reset();
        send_word(32'h01020304);
        send_word(32'hFFFFFFFF);
        idle_cycle();
        n_cmp++;
        if (wq_addr.size() !== 0 || word_count !== 8'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL nostart: writes=%0d wc=%0d busy=%b want 0 0 0", wq_addr.size(), word_count, busy);
        end
    endtask

    task automatic test_overflow();
        int bad;
        wq_addr.delete();
        wq_data.delete();
        pulse_start();
        for (int i = 0; i < 128; i++) send_word(32'h00000001);
        n_cmp++;
        if ({en_write, wr_addr} !== {1'b1, 7'd127}) begin
            n_err++;
            $display("FAIL ovf_last: en=%b addr=%0d want 1 127", en_write, wr_addr);
        end
        idle_cycle();
        n_cmp++;
        if ({busy, load_done, overflow, word_count} !== {1'b0, 1'b1, 1'b1, 8'd128}) begin
            n_err++;
            $display("FAIL ovf_flags: busy=%b done=%b ovf=%b wc=%0d want 0 1 1 128", busy, load_done, overflow, word_count);
        end
        bad = 0;
        for (int i = 0; i < wq_addr.size(); i++)
            if (wq_addr[i] !== 7'(i) || wq_data[i] !== 32'h00000001) bad++;
        n_cmp++;
        if (wq_addr.size() !== 128 || bad !== 0) begin
            n_err++;
            $display("FAIL ovf_seq: writes=%0d bad=%0d want 128 0", wq_addr.size(), bad);
        end
        send_word(32'h00000001);
        idle_cycle();
        n_cmp++;
        if (wq_addr.size() !== 128 || word_count !== 8'd128) begin
            n_err++;
            $display("FAIL ovf_129th: writes=%0d wc=%0d want 128 128", wq_addr.size(), word_count);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_byte(8'hAB);
        send_byte(8'hCD);
        test_reset();
        pulse_start();
        send_word(32'h8C220004);
        n_cmp++;
        if ({en_write, wr_addr, instr} !== {1'b1, 7'd0, 32'h8C220004}) begin
            n_err++;
            $display("FAIL rstmid_w: en=%b addr=%0d instr=%h want 1 0 8c220004", en_write, wr_addr, instr);
        end
        idle_cycle();
        n_cmp++;
        if (wq_addr.size() !== 1 || word_count !== 8'd1) begin
            n_err++;
            $display("FAIL rstmid_count: writes=%0d wc=%0d want 1 1", wq_addr.size(), word_count);
        end
    endtask

    task automatic test_restart();
        test_reset();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h02);
        pulse_start();
        send_byte(8'h03);
        send_byte(8'h04);
        n_cmp++;
        if ({en_write, wr_addr, instr} !== {1'b1, 7'd0, 32'h01020304}) begin
            n_err++;
            $display("FAIL busystart_w0: en=%b addr=%0d instr=%h want 1 0 01020304", en_write, wr_addr, instr);
        end
        send_word(32'h11223344);
        n_cmp++;
        if ({en_write, wr_addr, instr} !== {1'b1, 7'd1, 32'h11223344}) begin
            n_err++;
            $display("FAIL busystart_w1: en=%b addr=%0d instr=%h want 1 1 11223344", en_write, wr_addr, instr);
        end
        send_word(32'hFFFFFFFF);
        idle_cycle();
        n_cmp++;
        if ({load_done, word_count} !== {1'b1, 8'd3}) begin
            n_err++;
            $display("FAIL restart_done: done=%b wc=%0d want 1 3", load_done, word_count);
        end
        pulse_start();
        n_cmp++;
        if ({busy, load_done, overflow, word_count} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
            n_err++;
            $display("FAIL restart_clear: busy=%b done=%b ovf=%b wc=%0d want 1 0 0 0", busy, load_done, overflow, word_count);
        end
        send_word(32'hAABBCCDD);
        n_cmp++;
        if ({en_write, wr_addr, instr} !== {1'b1, 7'd0, 32'hAABBCCDD}) begin
            n_err++;
            $display("FAIL restart_w0: en=%b addr=%0d instr=%h want 1 0 aabbccdd", en_write, wr_addr, instr);
        end
        idle_cycle();
        n_cmp++;
        if ({en_write, busy, word_count} !== {1'b0, 1'b1, 8'd1}) begin
            n_err++;
            $display("FAIL restart_after: en=%b busy=%b wc=%0d want 0 1 1", en_write, busy, word_count);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        rx_done = 1'b0;
        rx_data = 8'h00;
        test_reset();
        test_program();
        test_ignore_in_done();
        test_no_start();
        test_overflow();
        test_reset_mid();
        test_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
